// File: rtl/bottle_station_ctrl_if.sv
// Station-side signal bundle for the bottle filling line: the two raw IR
// sensors coming in, pump/stepper drive and status pulses going out.
interface bottle_station_ctrl_if;
  logic       ir_pumpa;          // pump-station IR, 0 = bottle present
  logic       ir_zatvaranje;     // capping-station IR, 0 = bottle present
  logic       pumpa;             // pump enable
  logic [3:0] motor_zatvaranje;  // capping-stepper coil pattern
  logic       pump_busy;
  logic       cap_busy;
  logic       fill_done;
  logic       fill_fault;
  logic       cap_done;

  // Sensor side / status consumer (line model, Raspberry Pi glue, bench)
  modport master (
    output ir_pumpa, ir_zatvaranje,
    input  pumpa, motor_zatvaranje, pump_busy, cap_busy,
           fill_done, fill_fault, cap_done
  );

  // Station controller side
  modport slave (
    input  ir_pumpa, ir_zatvaranje,
    output pumpa, motor_zatvaranje, pump_busy, cap_busy,
           fill_done, fill_fault, cap_done
  );
endinterface

// File: rtl/bottle_station_ctrl.sv
// Station controller: filters the pump and capping IR sensors, fills a bottle
// for a fixed time at the pump station and runs one down/dwell/up stroke of
// the capping-head stepper at the capping station. The two stations are
// fully independent.
module bottle_station_ctrl #(
  parameter int unsigned DEBOUNCE   = 1000,
  parameter int unsigned FILL_TIME  = 750_000_000,
  parameter int unsigned STEP_DELAY = 200_000,
  parameter int unsigned CAP_STEPS  = 3000,
  parameter int unsigned DWELL_TIME = 50_000_000
) (
  input logic                  clk,
  input logic                  rst,
  bottle_station_ctrl_if.slave bus
);

  // Pump FSM encoding
  localparam logic [1:0] P_IDLE       = 2'd0;
  localparam logic [1:0] P_FILL       = 2'd1;
  localparam logic [1:0] P_WAIT_CLEAR = 2'd2;

  // Cap FSM encoding
  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_DOWN  = 2'd1;
  localparam logic [1:0] C_DWELL = 2'd2;
  localparam logic [1:0] C_UP    = 2'd3;

  // Sensor index 0 = pump station, 1 = capping station
  logic [1:0]  sync1, sync2;
  logic [1:0]  filt, filt_d;
  logic [31:0] deb_cnt [2];
  logic [1:0]  arrival;

  logic [1:0]  p_state;
  logic [31:0] fill_cnt;
  logic        fill_done_q, fill_fault_q;

  logic [1:0]  c_state;
  logic [1:0]  ph;
  logic [31:0] tmr;
  logic [31:0] steps;
  logic        cap_done_q;
  logic [3:0]  coil;

  // Synchronize both sensors, then accept a new level only after it has
  // disagreed with the filtered level for DEBOUNCE consecutive cycles.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // in the block samples pre-edge values, independent of statement order.
    if (rst) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      filt   <= 2'b11;
      filt_d <= 2'b11;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1  <= {bus.ir_zatvaranje, bus.ir_pumpa};
      sync2  <= sync1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != filt[i]) begin
          if (deb_cnt[i] == DEBOUNCE - 1) begin
            filt[i]    <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 32'd1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // A bottle arrives on a filtered 1->0 transition; single-cycle event.
  assign arrival = filt_d & ~filt;

  // Pump FSM: fill for FILL_TIME cycles, abort if the bottle leaves early,
  // then wait for removal so a bottle left in place is filled only once.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_state      <= P_IDLE;
      fill_cnt     <= '0;
      fill_done_q  <= 1'b0;
      fill_fault_q <= 1'b0;
    end else begin
      fill_done_q  <= 1'b0;
      fill_fault_q <= 1'b0;
      case (p_state)
        P_IDLE: begin
          if (arrival[0]) begin
            p_state  <= P_FILL;
            fill_cnt <= '0;
          end
        end
        P_FILL: begin
          // Running the full fill time wins over a removal seen on the
          // very last cycle: the bottle did receive its full dose.
          if (fill_cnt == FILL_TIME - 1) begin
            p_state     <= P_WAIT_CLEAR;
            fill_done_q <= 1'b1;
          end else if (filt[0]) begin
            p_state      <= P_IDLE;
            fill_fault_q <= 1'b1;
          end else begin
            fill_cnt <= fill_cnt + 32'd1;
          end
        end
        P_WAIT_CLEAR: begin
          if (filt[0]) p_state <= P_IDLE;
        end
        default: p_state <= P_IDLE;
      endcase
    end
  end

  // Cap FSM: step the head down CAP_STEPS times, dwell, step back up the
  // same count so the phase index ends where it started. Sensor changes
  // after the start are ignored so the head is never left down.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_state    <= C_IDLE;
      ph         <= 2'd0;
      tmr        <= '0;
      steps      <= '0;
      cap_done_q <= 1'b0;
    end else begin
      cap_done_q <= 1'b0;
      case (c_state)
        C_IDLE: begin
          if (arrival[1]) begin
            c_state <= C_DOWN;
            tmr     <= '0;
            steps   <= '0;
          end
        end
        C_DOWN: begin
          if (tmr == STEP_DELAY - 1) begin
            tmr <= '0;
            ph  <= ph + 2'd1;
            if (steps == CAP_STEPS - 1) begin
              c_state <= C_DWELL;
              steps   <= '0;
            end else begin
              steps <= steps + 32'd1;
            end
          end else begin
            tmr <= tmr + 32'd1;
          end
        end
        C_DWELL: begin
          if (tmr == DWELL_TIME - 1) begin
            tmr     <= '0;
            c_state <= C_UP;
          end else begin
            tmr <= tmr + 32'd1;
          end
        end
        C_UP: begin
          if (tmr == STEP_DELAY - 1) begin
            tmr <= '0;
            ph  <= ph - 2'd1;
            if (steps == CAP_STEPS - 1) begin
              c_state    <= C_IDLE;
              steps      <= '0;
              cap_done_q <= 1'b1;
            end else begin
              steps <= steps + 32'd1;
            end
          end else begin
            tmr <= tmr + 32'd1;
          end
        end
        default: c_state <= C_IDLE;
      endcase
    end
  end

  // Coil pattern for the current phase; coils de-energized when idle.
  always_comb begin
    // NOTE: default assignment first so every path drives coil and no latch
    // is inferred.
    coil = 4'b0000;
    if (c_state != C_IDLE) begin
      case (ph)
        2'd0:    coil = 4'b1100;
        2'd1:    coil = 4'b0110;
        2'd2:    coil = 4'b0011;
        default: coil = 4'b1001;
      endcase
    end
  end

  assign bus.pumpa            = (p_state == P_FILL);
  assign bus.pump_busy        = (p_state != P_IDLE);
  assign bus.fill_done        = fill_done_q;
  assign bus.fill_fault       = fill_fault_q;
  assign bus.motor_zatvaranje = coil;
  assign bus.cap_busy         = (c_state != C_IDLE);
  assign bus.cap_done         = cap_done_q;

endmodule

// File: tb/tb_bottle_station_ctrl.sv
// Bench for bottle_station_ctrl with short timing parameters. Cycle t is the
// interval after the t-th rising edge following reset release; outputs are
// sampled and inputs driven on the falling edge inside that cycle.
module tb_bottle_station_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bottle_station_ctrl_if bus ();

  bottle_station_ctrl #(
    .DEBOUNCE  (4),
    .FILL_TIME (20),
    .STEP_DELAY(3),
    .CAP_STEPS (5),
    .DWELL_TIME(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int base   = 0;

  typedef struct {
    int         t;       // relative cycle of the check
    logic       p_in;    // ir_pumpa driven after the check
    logic       z_in;    // ir_zatvaranje driven after the check
    logic       pumpa;
    logic       pbusy;
    logic       fdone;
    logic       ffault;
    logic [3:0] coil;
    logic       cbusy;
    logic       cdone;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int t, input logic p_in, input logic z_in,
                              input logic pumpa, input logic pbusy,
                              input logic fdone, input logic ffault,
                              input logic [3:0] coil, input logic cbusy,
                              input logic cdone);
    vec_t v;
    v.t = t; v.p_in = p_in; v.z_in = z_in;
    v.pumpa = pumpa; v.pbusy = pbusy; v.fdone = fdone; v.ffault = ffault;
    v.coil = coil; v.cbusy = cbusy; v.cdone = cdone;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input vec_t v);
    check($sformatf("t%0d pumpa", v.t),      32'(bus.pumpa),            32'(v.pumpa));
    check($sformatf("t%0d pump_busy", v.t),  32'(bus.pump_busy),        32'(v.pbusy));
    check($sformatf("t%0d fill_done", v.t),  32'(bus.fill_done),        32'(v.fdone));
    check($sformatf("t%0d fill_fault", v.t), 32'(bus.fill_fault),       32'(v.ffault));
    check($sformatf("t%0d motor", v.t),      32'(bus.motor_zatvaranje), 32'(v.coil));
    check($sformatf("t%0d cap_busy", v.t),   32'(bus.cap_busy),         32'(v.cbusy));
    check($sformatf("t%0d cap_done", v.t),   32'(bus.cap_done),         32'(v.cdone));
  endtask

  task automatic go_to(input int t);
    while (cyc - base < t) @(negedge clk);
  endtask

  initial begin
    //   t   p  z   pumpa pbusy fdone ffault coil     cbusy cdone
    // Glitch: 3 low cycles are rejected (4 would be accepted)
    add(  0, 0, 1,  0, 0, 0, 0, 4'b0000, 0, 0);
    add(  3, 1, 1,  0, 0, 0, 0, 4'b0000, 0, 0);
    add(  8, 1, 1,  0, 0, 0, 0, 4'b0000, 0, 0);
    add( 14, 1, 1,  0, 0, 0, 0, 4'b0000, 0, 0);
    // Normal fill: low at 20 -> pumpa over 27..46, fill_done at 47
    add( 20, 0, 1,  0, 0, 0, 0, 4'b0000, 0, 0);
    add( 26, 0, 1,  0, 0, 0, 0, 4'b0000, 0, 0);
    add( 27, 0, 1,  1, 1, 0, 0, 4'b0000, 0, 0);
    add( 46, 0, 1,  1, 1, 0, 0, 4'b0000, 0, 0);
    add( 47, 0, 1,  0, 1, 1, 0, 4'b0000, 0, 0);
    add( 48, 0, 1,  0, 1, 0, 0, 4'b0000, 0, 0);
    // Still held low: no refill; release at 70 -> idle at 77
    add( 70, 1, 1,  0, 1, 0, 0, 4'b0000, 0, 0);
    add( 76, 1, 1,  0, 1, 0, 0, 4'b0000, 0, 0);
    add( 77, 1, 1,  0, 0, 0, 0, 4'b0000, 0, 0);
    // Second bottle: low at 80 -> pumpa 87..106, done at 107
    add( 80, 0, 1,  0, 0, 0, 0, 4'b0000, 0, 0);
    add( 87, 0, 1,  1, 1, 0, 0, 4'b0000, 0, 0);
    add(106, 0, 1,  1, 1, 0, 0, 4'b0000, 0, 0);
    add(107, 1, 1,  0, 1, 1, 0, 4'b0000, 0, 0);
    add(113, 1, 1,  0, 1, 0, 0, 4'b0000, 0, 0);
    add(114, 1, 1,  0, 0, 0, 0, 4'b0000, 0, 0);
    // Abort: pumpa from 127, released after 10 pump cycles -> fault at 144
    add(120, 0, 1,  0, 0, 0, 0, 4'b0000, 0, 0);
    add(127, 0, 1,  1, 1, 0, 0, 4'b0000, 0, 0);
    add(137, 1, 1,  1, 1, 0, 0, 4'b0000, 0, 0);
    add(143, 1, 1,  1, 1, 0, 0, 4'b0000, 0, 0);
    add(144, 1, 1,  0, 0, 0, 1, 4'b0000, 0, 0);
    add(145, 1, 1,  0, 0, 0, 0, 4'b0000, 0, 0);
    // Capping stroke: low at 160 -> entry 167, steps every 3, dwell 182..191
    add(160, 1, 0,  0, 0, 0, 0, 4'b0000, 0, 0);
    add(166, 1, 0,  0, 0, 0, 0, 4'b0000, 0, 0);
    add(167, 1, 0,  0, 0, 0, 0, 4'b1100, 1, 0);
    add(169, 1, 0,  0, 0, 0, 0, 4'b1100, 1, 0);
    add(170, 1, 0,  0, 0, 0, 0, 4'b0110, 1, 0);
    add(173, 1, 0,  0, 0, 0, 0, 4'b0011, 1, 0);
    add(176, 1, 0,  0, 0, 0, 0, 4'b1001, 1, 0);
    add(179, 1, 0,  0, 0, 0, 0, 4'b1100, 1, 0);
    add(182, 1, 0,  0, 0, 0, 0, 4'b0110, 1, 0);
    add(191, 1, 0,  0, 0, 0, 0, 4'b0110, 1, 0);
    add(194, 1, 0,  0, 0, 0, 0, 4'b0110, 1, 0);
    add(195, 1, 0,  0, 0, 0, 0, 4'b1100, 1, 0);
    add(198, 1, 0,  0, 0, 0, 0, 4'b1001, 1, 0);
    add(201, 1, 0,  0, 0, 0, 0, 4'b0011, 1, 0);
    add(204, 1, 0,  0, 0, 0, 0, 4'b0110, 1, 0);
    add(206, 1, 0,  0, 0, 0, 0, 4'b0110, 1, 0);
    add(207, 1, 0,  0, 0, 0, 0, 4'b0000, 0, 1);
    add(208, 1, 1,  0, 0, 0, 0, 4'b0000, 0, 0);
    // Both stations at once (entry 237); cap bottle removed at 240, ignored
    add(230, 0, 0,  0, 0, 0, 0, 4'b0000, 0, 0);
    add(236, 0, 0,  0, 0, 0, 0, 4'b0000, 0, 0);
    add(237, 0, 0,  1, 1, 0, 0, 4'b1100, 1, 0);
    add(240, 0, 1,  1, 1, 0, 0, 4'b0110, 1, 0);
    add(252, 0, 1,  1, 1, 0, 0, 4'b0110, 1, 0);
    add(256, 0, 1,  1, 1, 0, 0, 4'b0110, 1, 0);
    add(257, 0, 1,  0, 1, 1, 0, 4'b0110, 1, 0);
    add(260, 1, 1,  0, 1, 0, 0, 4'b0110, 1, 0);
    add(266, 1, 1,  0, 1, 0, 0, 4'b1100, 1, 0);
    add(267, 1, 1,  0, 0, 0, 0, 4'b1100, 1, 0);
    add(277, 1, 1,  0, 0, 0, 0, 4'b0000, 0, 1);
    add(278, 1, 1,  0, 0, 0, 0, 4'b0000, 0, 0);

    bus.ir_pumpa      = 1'b1;
    bus.ir_zatvaranje = 1'b1;
    rst               = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    base = cyc;

    for (int i = 0; i < tbl.size(); i++) begin
      go_to(tbl[i].t);
      check_vec(tbl[i]);
      bus.ir_pumpa      = tbl[i].p_in;
      bus.ir_zatvaranje = tbl[i].z_in;
    end

    // Reset mid-stroke: bottle at 278 -> entry 285, dwell 300..309
    bus.ir_zatvaranje = 1'b0;
    go_to(303);
    check("rst pre motor", 32'(bus.motor_zatvaranje), 32'h6);
    check("rst pre cap_busy", 32'(bus.cap_busy), 32'h1);
    rst = 1'b1;
    go_to(304);
    check("rst motor", 32'(bus.motor_zatvaranje), 32'h0);
    check("rst cap_busy", 32'(bus.cap_busy), 32'h0);
    check("rst cap_done", 32'(bus.cap_done), 32'h0);
    check("rst pumpa", 32'(bus.pumpa), 32'h0);
    go_to(305);
    rst = 1'b0;
    // Sensor still low: filter restarted at 1, re-arrival enters at 312
    go_to(311);
    check("rearm idle motor", 32'(bus.motor_zatvaranje), 32'h0);
    check("rearm idle cap_busy", 32'(bus.cap_busy), 32'h0);
    go_to(312);
    check("rearm start motor", 32'(bus.motor_zatvaranje), 32'hC);
    check("rearm start cap_busy", 32'(bus.cap_busy), 32'h1);
    go_to(315);
    check("rearm step motor", 32'(bus.motor_zatvaranje), 32'h6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
